// File: rtl/wbuart_tx_scheduler.sv
// wbuart_tx_scheduler
// Arbitrates NREQ byte requesters onto a Wishbone-attached UART. Each granted
// byte is sent by polling SR until TXE (bit 1) is set, then writing TXDR.
// A pending CR write request always wins over requesters when idle.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/data_i    per-requester byte offer (byte i at [8i+7:8i])
//   req_ready_o           one-hot accept strobe, only ever high in IDLE
//   cfg_write_i/cfg_cr_i  request to program CR, value captured on accept
//   busy_o                high whenever the scheduler is not idle
//   sent_count_o          bytes written to TXDR (wraps)
//   wb_*                  pipelined Wishbone B4 master, one transfer per cycle
module wbuart_tx_scheduler #(
    parameter int unsigned NREQ      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [8*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic                cfg_write_i,
    input  logic [31:0]         cfg_cr_i,
    output logic                busy_o,
    output logic [15:0]         sent_count_o,
    output logic [31:0]         wb_adr_o,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    output logic                wb_we_o,
    output logic [3:0]          wb_sel_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    output logic                wb_cyc_o,
    input  logic                wb_stall_i
);

    localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] SR_ADDR   = BASE_ADDR;
    localparam logic [31:0] CR_ADDR   = BASE_ADDR + 32'h4;
    localparam logic [31:0] TXDR_ADDR = BASE_ADDR + 32'hC;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CFG_REQ  = 3'd1,
        S_CFG_ACK  = 3'd2,
        S_POLL_REQ = 3'd3,
        S_POLL_ACK = 3'd4,
        S_WR_REQ   = 3'd5,
        S_WR_ACK   = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   last_grant_q;
    logic [7:0]         byte_q;
    logic [31:0]        cr_q;
    logic [15:0]        sent_count_q;

    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               cfg_take;
    logic               req_take;

    // Only TXE is inspected from the status word.
    logic               unused_wb_dat;
    assign unused_wb_dat = ^{wb_dat_i[31:2], wb_dat_i[0]};

    // Round-robin pick: scan from the farthest candidate back to the nearest so
    // the first valid index strictly after last_grant is the one left standing.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            cand = IDX_W'((32'(last_grant_q) + k) % NREQ);
            if (req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Acceptance only in IDLE and never while reset is asserted; CR wins.
    assign cfg_take = (state_q == S_IDLE) && !rst_i && cfg_write_i;
    assign req_take = (state_q == S_IDLE) && !rst_i && !cfg_write_i && grant_any;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acks are only looked at in the *_ACK states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_take) begin
                    state_d = S_CFG_REQ;
                end else if (req_take) begin
                    state_d = S_POLL_REQ;
                end
            end
            S_CFG_REQ:  if (!wb_stall_i) state_d = S_CFG_ACK;
            S_CFG_ACK:  if (wb_ack_i)    state_d = S_IDLE;
            S_POLL_REQ: if (!wb_stall_i) state_d = S_POLL_ACK;
            S_POLL_ACK: begin
                if (wb_ack_i) begin
                    state_d = wb_dat_i[1] ? S_WR_REQ : S_POLL_REQ;
                end
            end
            S_WR_REQ:   if (!wb_stall_i) state_d = S_WR_ACK;
            S_WR_ACK:   if (wb_ack_i)    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero whenever stb is low.
    always_comb begin
        req_ready_o = '0;
        busy_o      = (state_q != S_IDLE);
        wb_cyc_o    = (state_q != S_IDLE);
        wb_stb_o    = 1'b0;
        wb_adr_o    = '0;
        wb_dat_o    = '0;
        wb_we_o     = 1'b0;
        wb_sel_o    = '0;
        if (req_take) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        case (state_q)
            S_CFG_REQ: begin
                wb_stb_o = 1'b1;
                wb_adr_o = CR_ADDR;
                wb_dat_o = cr_q;
                wb_we_o  = 1'b1;
                wb_sel_o = 4'hF;
            end
            S_POLL_REQ: begin
                wb_stb_o = 1'b1;
                wb_adr_o = SR_ADDR;
                wb_sel_o = 4'hF;
            end
            S_WR_REQ: begin
                wb_stb_o = 1'b1;
                wb_adr_o = TXDR_ADDR;
                wb_dat_o = {24'b0, byte_q};
                wb_we_o  = 1'b1;
                wb_sel_o = 4'hF;
            end
            default: ;
        endcase
    end

    // Captured payloads, arbitration pointer and sent counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= IDX_W'(NREQ - 1);
            byte_q       <= '0;
            cr_q         <= '0;
            sent_count_q <= '0;
        end else begin
            if (cfg_take) begin
                cr_q <= cfg_cr_i;
            end
            if (req_take) begin
                byte_q       <= req_data_i[8*grant_idx +: 8];
                last_grant_q <= grant_idx;
            end
            if ((state_q == S_WR_ACK) && wb_ack_i) begin
                sent_count_q <= sent_count_q + 16'd1;
            end
        end
    end

    assign sent_count_o = sent_count_q;

endmodule

// File: tb/tb_wbuart_tx_scheduler.sv
// Bench for wbuart_tx_scheduler: Wishbone slave model with stall/ack-delay
// knobs, round-robin grant model, directed vector table, hand sequences for
// priority and reset, then a randomized run.
module tb_wbuart_tx_scheduler;

    localparam int          NREQ = 4;
    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam logic [31:0] SR_A = BASE;
    localparam logic [31:0] CR_A = BASE + 32'h4;
    localparam logic [31:0] TX_A = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_write;
    logic [31:0] cfg_cr;
    logic        busy;
    logic [15:0] sent_count;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        wb_we, wb_stb, wb_ack, wb_cyc, wb_stall;
    logic [3:0]  wb_sel;

    always #5 clk = ~clk;

    wbuart_tx_scheduler #(.NREQ(NREQ), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .cfg_write_i(cfg_write), .cfg_cr_i(cfg_cr),
        .busy_o(busy), .sent_count_o(sent_count),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb),
        .wb_ack_i(wb_ack), .wb_cyc_o(wb_cyc), .wb_stall_i(wb_stall)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] bytes;
        int          nr_polls;
        int          wr_stall;
        bit          spur;
        int          exp_grant;
        int          exp_reads;
        logic [7:0]  exp_byte;
        int          exp_count;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;

    // slave knobs and state
    int          stall_wr = 0, stall_rd = 0, ack_delay = 0;
    bit          spur = 0, sr_rand = 0;
    int          stall_left = 0, hold = 0, ack_cnt = 0;
    bit          in_req = 0, spur_done = 0;
    logic [31:0] ack_dat = '0, f_adr, f_dat;
    logic [4:0]  f_ctl;
    logic [31:0] sr_q[$];

    // model state and logs
    int          m_last = NREQ - 1;
    int          exp_cnt = 0;
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_cr[$];
    int          ops[$];
    int          g_hist[$];
    int          g_cnt = 0, g_seen = -1;
    int          n_rd = 0, n_wr = 0, n_nr = 0;
    int          last_wr_hold = 0;
    logic [31:0] last_wr_dat = '0;
    bit          cfg_seen = 0;
    bit [3:0]    gflag = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic record(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        if (we) begin
            chk("wr_sel", 32'(sel), 32'hF);
            if (adr == TX_A) begin
                ops.push_back(3);
                n_wr++;
                last_wr_dat  = dat;
                last_wr_hold = hold + 1;
                if (exp_bytes.size() == 0) chk("txdr_unexpected", 32'd1, 32'd0);
                else chk("txdr_data", dat, {24'b0, exp_bytes.pop_front()});
                exp_cnt++;
            end else begin
                ops.push_back(1);
                chk("wr_addr", adr, CR_A);
                if (exp_cr.size() == 0) chk("cr_unexpected", 32'd1, 32'd0);
                else chk("cr_data", dat, exp_cr.pop_front());
            end
            ack_dat = '0;
        end else begin
            ops.push_back(2);
            n_rd++;
            chk("rd_addr", adr, SR_A);
            if (sr_q.size() != 0) ack_dat = sr_q.pop_front();
            else if (sr_rand && ($urandom % 3 == 0)) ack_dat = $urandom & ~32'h2;
            else if (sr_rand) ack_dat = $urandom | 32'h2;
            else ack_dat = 32'h2;
            if (!ack_dat[1]) n_nr++;
        end
    endtask

    // Negedge work: protocol checks, grant model, Wishbone slave.
    task automatic observe();
        int exp_g;
        int act_g;
        if (!wb_stb && (wb_adr != 0 || wb_dat_o != 0 || wb_we || wb_sel != 0)) viol++;
        if (wb_stb && !wb_cyc) viol++;
        if (req_ready != 0 && (!$onehot(req_ready) || (req_ready & ~req_valid) != 0 ||
                               cfg_write || wb_cyc || rst_i)) viol++;
        wb_ack   = 1'b0;
        wb_dat_i = '1;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                wb_ack   = 1'b1;
                wb_dat_i = ack_dat;
            end
        end
        if (rst_i) begin
            m_last = NREQ - 1;
            exp_cnt = 0;
            exp_bytes.delete();
            exp_cr.delete();
            sr_q.delete();
            in_req = 0;
            stall_left = 0;
            wb_stall = 1'b0;
            gflag = '0;
        end else begin
            if (req_ready != 0) begin
                exp_g = -1;
                act_g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (exp_g < 0 && req_valid[(m_last + k) % NREQ]) exp_g = (m_last + k) % NREQ;
                end
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) act_g = i;
                chk("rr_grant", 32'(act_g), 32'(exp_g));
                g_cnt++;
                g_seen = act_g;
                g_hist.push_back(act_g);
                gflag[act_g] = 1'b1;
                if (exp_g >= 0) begin
                    m_last = exp_g;
                    exp_bytes.push_back(req_data[8*exp_g +: 8]);
                end
            end
            if (wb_stb) begin
                if (wb_adr == CR_A) cfg_seen = 1;
                if (!in_req) begin
                    in_req = 1;
                    stall_left = wb_we ? stall_wr : stall_rd;
                    hold = 0;
                    spur_done = 0;
                    f_adr = wb_adr;
                    f_dat = wb_dat_o;
                    f_ctl = {wb_we, wb_sel};
                end else begin
                    chk("stall_adr", wb_adr, f_adr);
                    chk("stall_dat", wb_dat_o, f_dat);
                    chk("stall_ctl", 32'({wb_we, wb_sel}), 32'(f_ctl));
                end
                if (stall_left > 0) begin
                    wb_stall = 1'b1;
                    stall_left--;
                    hold++;
                    if (spur && !spur_done) begin
                        wb_ack = 1'b1;
                        wb_dat_i = 32'h2;
                        spur_done = 1;
                    end
                end else begin
                    wb_stall = 1'b0;
                    in_req = 0;
                    record(wb_we, wb_adr, wb_dat_o, wb_sel);
                    ack_cnt = 1 + ack_delay;
                end
            end else begin
                wb_stall = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic wait_grant(input int bound);
        int g0 = g_cnt;
        for (int c = 0; c < bound && g_cnt == g0; c++) step();
        if (g_cnt == g0) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int c = 0; c < bound && busy; c++) step();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    vec_t tbl[6];
    int   exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        int g0;
        tbl[0] = '{4'b0001, 32'h0000_0041, 0, 0, 1'b0, 0, 1, 8'h41, 1};
        tbl[1] = '{4'b0011, 32'h0000_2210, 3, 0, 1'b0, 1, 4, 8'h22, 2};
        tbl[2] = '{4'b0101, 32'h0055_0033, 0, 3, 1'b1, 2, 1, 8'h55, 3};
        tbl[3] = '{4'b0001, 32'h0000_0066, 0, 0, 1'b0, 0, 1, 8'h66, 4};
        tbl[4] = '{4'b1000, 32'h7700_0000, 0, 0, 1'b0, 3, 1, 8'h77, 5};
        tbl[5] = '{4'b1001, 32'h9900_0088, 0, 0, 1'b0, 0, 1, 8'h88, 6};

        rst_i = 1'b1; req_valid = 4'hF; req_data = 32'hDEAD_BEEF;
        cfg_write = 1'b0; cfg_cr = '0;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_dat_i = '0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_count", 32'(sent_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_i = 1'b0;
        req_valid = '0;

        // Directed single-byte vectors; grant expectations follow history.
        for (int r = 0; r < 6; r++) begin
            n_rd = 0; n_wr = 0; g0 = g_cnt;
            stall_wr = tbl[r].wr_stall; stall_rd = 0; spur = tbl[r].spur;
            for (int p = 0; p < tbl[r].nr_polls; p++) sr_q.push_back(32'h0);
            req_data = tbl[r].bytes;
            req_valid = tbl[r].valid;
            wait_grant(20);
            req_valid = '0;
            req_data = 32'h5A5A_5A5A;
            wait_idle(100);
            chk("row_grant", 32'(g_seen), 32'(tbl[r].exp_grant));
            chk("row_ngrant", 32'(g_cnt - g0), 32'd1);
            chk("row_reads", 32'(n_rd), 32'(tbl[r].exp_reads));
            chk("row_writes", 32'(n_wr), 32'd1);
            chk("row_txdr", last_wr_dat, {24'b0, tbl[r].exp_byte});
            chk("row_count", 32'(sent_count), 32'(tbl[r].exp_count));
            chk("row_wr_stb_cycles", 32'(last_wr_hold), 32'(tbl[r].wr_stall + 1));
        end
        stall_wr = 0; spur = 0;

        // Reset in POLL_ACK with a late ack still outstanding.
        ack_delay = 3;
        repeat (4) sr_q.push_back(32'h0);
        req_data = 32'h0000_C300;
        req_valid = 4'b0010;
        wait_grant(20);
        chk("mid_grant", 32'(g_seen), 32'd1);
        req_valid = '0;
        for (int c = 0; c < 20 && !(wb_cyc && !wb_stb); c++) step();
        chk("mid_in_poll_ack", 32'({wb_cyc, wb_stb}), 32'b10);
        rst_i = 1'b1;
        step();
        chk("mid_rst_cyc_stb", 32'({wb_cyc, wb_stb}), 32'd0);
        chk("mid_rst_count", 32'(sent_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_i = 1'b0;
        ack_delay = 0;
        req_data = 32'h0013_1211;
        req_valid = 4'b0111;
        wait_grant(20);
        chk("post_rst_grant", 32'(g_seen), 32'd0);
        req_valid = '0;
        wait_idle(100);
        chk("post_rst_count", 32'(sent_count), 32'd1);

        // All requesters valid continuously: fair rotation.
        do_reset();
        g_hist.delete();
        n_wr = 0;
        req_data = 32'hA3A2_A1A0;
        req_valid = 4'hF;
        for (int c = 0; c < 200 && g_hist.size() < 5; c++) step();
        req_valid = '0;
        wait_idle(100);
        chk("rr_ngrants", 32'(g_hist.size()), 32'd5);
        for (int k = 0; k < 5 && k < g_hist.size(); k++) chk("rr_order", 32'(g_hist[k]), 32'(exp_rr[k]));
        chk("rr_writes", 32'(n_wr), 32'd5);
        chk("rr_count", 32'(sent_count), 32'd5);

        // Config and request offered together: CR write first.
        do_reset();
        ops.delete();
        g0 = g_cnt;
        exp_cr.push_back(32'h01B2_0000);
        cfg_cr = 32'h01B2_0000;
        cfg_write = 1'b1;
        req_data = 32'h0000_5A00;
        req_valid = 4'b0010;
        step();
        cfg_write = 1'b0;
        wait_grant(20);
        req_valid = '0;
        wait_idle(100);
        chk("cfg_nops", 32'(ops.size()), 32'd3);
        if (ops.size() == 3) begin
            chk("cfg_op0", 32'(ops[0]), 32'd1);
            chk("cfg_op1", 32'(ops[1]), 32'd2);
            chk("cfg_op2", 32'(ops[2]), 32'd3);
        end
        chk("cfg_grant", 32'(g_seen), 32'd1);
        chk("cfg_ngrant", 32'(g_cnt - g0), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        n_rd = 0; n_wr = 0; n_nr = 0;
        sr_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (gflag[i]) begin
                    gflag[i] = 1'b0;
                    if ($urandom % 2 == 0) req_valid[i] = 1'b0;
                    else req_data[8*i +: 8] = 8'($urandom);
                end else if (!req_valid[i] && ($urandom % 5 == 0)) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if (cfg_write) begin
                if (cfg_seen) cfg_write = 1'b0;
            end else if ($urandom % 80 == 0) begin
                cfg_cr = $urandom;
                exp_cr.push_back(cfg_cr);
                cfg_seen = 0;
                cfg_write = 1'b1;
            end
            stall_wr = int'($urandom % 3);
            stall_rd = int'($urandom % 3);
            ack_delay = int'($urandom % 3);
            spur = ($urandom % 4 == 0);
        end
        req_valid = '0;
        for (int c = 0; c < 400 && (cfg_write || busy); c++) begin
            step();
            if (cfg_write && cfg_seen) cfg_write = 1'b0;
        end
        chk("rand_drain", 32'({cfg_write, busy}), 32'd0);
        chk("rand_bytes_left", 32'(exp_bytes.size()), 32'd0);
        chk("rand_cr_left", 32'(exp_cr.size()), 32'd0);
        chk("rand_count", 32'(sent_count), 32'(16'(exp_cnt)));
        chk("rand_reads", 32'(n_rd), 32'(n_wr + n_nr));
        chk("protocol_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
